// File: rtl/uart_rx_hub.sv
// -----------------------------------------------------------------------------
// uart_rx_hub
//   Multi-channel UART receive concentrator. Every serial input has its own
//   16x-oversampled receiver and byte FIFO; a round-robin arbiter merges all
//   FIFOs onto one valid/ready byte stream tagged with the source channel.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rxd        asynchronous serial inputs, one per channel, idle high
//   out_valid  output byte available
//   out_ready  consumer accepts the byte
//   out_data   received byte
//   out_ch     source channel of out_data (zero-extended index)
//   frame_err  one-cycle pulse per framing error, per channel
//   overflow   sticky per-channel flag: a byte was dropped on a full FIFO
//   ovf_clear  clears the matching overflow bit (a coincident set wins)
// -----------------------------------------------------------------------------
module uart_rx_hub #(
    parameter int NUM_CH     = 2,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] rxd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [NUM_CH-1:0] frame_err,
    output logic [NUM_CH-1:0] overflow,
    input  logic [NUM_CH-1:0] ovf_clear
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int          DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int          DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int          DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam int unsigned NCH     = NUM_CH;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    // ------------------------------------------------------------------
    // Shared 16x oversampling tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_W'(DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers; reset to the idle line level
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Cross-channel signals between the per-channel blocks and the arbiter
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] pop;
    logic [7:0]        head [NUM_CH];

    // ------------------------------------------------------------------
    // Per-channel receiver and FIFO
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        rx_state_e        st_q, st_d;
        logic [3:0]       scnt_q, scnt_d;
        logic [2:0]       bit_q, bit_d;
        logic [7:0]       sh_q, sh_d;
        logic             fe_q, fe_d;
        logic             push;

        logic [7:0]       mem_q [FIFO_DEPTH];
        logic [AW-1:0]    wr_q, wr_d;
        logic [AW-1:0]    rd_q, rd_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             ovf_q, ovf_d;
        logic             full;
        logic             wr_en;
        logic             rd_en;

        // Receiver next-state logic. The start midpoint is at count 7; every
        // later sample is 16 ticks further on, so data and stop bits are
        // taken when the counter wraps from 15.
        always_comb begin
            st_d   = st_q;
            scnt_d = scnt_q;
            bit_d  = bit_q;
            sh_d   = sh_q;
            fe_d   = 1'b0;
            push   = 1'b0;
            unique case (st_q)
                RX_IDLE: begin
                    if (!sync2_q[g]) begin
                        scnt_d = '0;
                        st_d   = RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (scnt_q == 4'd7) begin
                            scnt_d = '0;
                            if (!sync2_q[g]) begin
                                bit_d = '0;
                                st_d  = RX_DATA;
                            end else begin
                                st_d  = RX_IDLE;
                            end
                        end else begin
                            scnt_d = scnt_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (scnt_q == 4'd15) begin
                            scnt_d = '0;
                            sh_d   = {sync2_q[g], sh_q[7:1]};
                            if (bit_q == 3'd7) begin
                                st_d = RX_STOP;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end else begin
                            scnt_d = scnt_q + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (scnt_q == 4'd15) begin
                            scnt_d = '0;
                            if (sync2_q[g]) begin
                                push = 1'b1;
                                st_d = RX_IDLE;
                            end else begin
                                fe_d = 1'b1;
                                st_d = RX_WAIT_IDLE;
                            end
                        end else begin
                            scnt_d = scnt_q + 4'd1;
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    if (sync2_q[g]) begin
                        st_d = RX_IDLE;
                    end
                end
                default: begin
                    st_d = RX_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st_q   <= RX_IDLE;
                scnt_q <= '0;
                bit_q  <= '0;
                sh_q   <= '0;
                fe_q   <= 1'b0;
            end else begin
                st_q   <= st_d;
                scnt_q <= scnt_d;
                bit_q  <= bit_d;
                sh_q   <= sh_d;
                fe_q   <= fe_d;
            end
        end

        // FIFO: a pop in the same cycle frees a slot, so a push into a full
        // FIFO only drops the byte when nothing is popped.
        always_comb begin
            full  = (cnt_q == CW'(FIFO_DEPTH));
            wr_en = push & (~full | pop[g]);
            rd_en = pop[g];
            wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
            rd_d  = rd_en ? rd_q + AW'(1) : rd_q;
            cnt_d = cnt_q;
            unique case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            ovf_d = (ovf_q & ~ovf_clear[g]) | (push & full & ~pop[g]);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        // Storage needs no reset: the pointers and count define validity.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_q] <= sh_q;
            end
        end

        assign nonempty[g]  = (cnt_q != '0);
        assign head[g]      = mem_q[rd_q];
        assign frame_err[g] = fe_q;
        assign overflow[g]  = ovf_q;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output register
    // ------------------------------------------------------------------
    logic            valid_q, valid_d;
    logic [7:0]      data_q, data_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            load;
    logic            found;
    logic [CH_W-1:0] gnt;

    always_comb begin
        int unsigned cand;
        cand  = 0;
        found = 1'b0;
        gnt   = '0;
        // Scan pointer+1 .. pointer+NUM_CH, wrapping; the pointer itself is
        // visited last so the previous winner has lowest priority.
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!found && nonempty[CH_W'(cand)]) begin
                found = 1'b1;
                gnt   = CH_W'(cand);
            end
        end
    end

    always_comb begin
        load    = ~valid_q | out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        pop     = '0;
        if (load) begin
            valid_d = found;
            if (found) begin
                data_d   = head[gnt];
                ch_d     = gnt;
                ptr_d    = gnt;
                pop[gnt] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule
